// File: rtl/unidade_controle_multiciclo_pkg.sv
// Shared definitions for the multicycle control unit: state encodings, opcodes,
// datapath select codes and the strobe bundle. HALT constant only with CONTROLE_HALT_EN.
package unidade_controle_multiciclo_pkg;

   typedef enum logic [2:0] {
      BUSCA      = 3'd0,
      DECODIFICA = 3'd1,
      EXECUTA    = 3'd2,
      MEMORIA    = 3'd3,
      ESCRITA    = 3'd4,
      PARADO     = 3'd5
   } estado_t;

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_AND = 3'b010;
   localparam logic [2:0] OP_OR  = 3'b011;
   localparam logic [2:0] OP_LW  = 3'b100;
   localparam logic [2:0] OP_SW  = 3'b101;
   localparam logic [2:0] OP_BEQ = 3'b110;
   localparam logic [2:0] OP_J   = 3'b111;

   localparam logic [1:0] ALUOP_SOMA  = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   localparam logic [1:0] SRCB_REGB = 2'b00;
   localparam logic [1:0] SRCB_UM   = 2'b01;
   localparam logic [1:0] SRCB_IMED = 2'b10;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_DESVIO = 2'b10;

   localparam logic [1:0] REGDST_RT    = 2'b00;
   localparam logic [1:0] REGDST_RD    = 2'b01;
   localparam logic [1:0] REGDST_CONST = 2'b10;

`ifdef CONTROLE_HALT_EN
   localparam logic [7:0] INSTR_HALT = 8'hFF;
`endif

   typedef struct packed {
      logic [1:0] reg_dst;
      logic       reg_write;
      logic       mem_read;
      logic       mem_write;
      logic       ir_write;
      logic       pc_write;
      logic       pc_write_cond;
      logic       iord;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] alu_op;
      logic [1:0] pc_source;
      logic       mem_to_reg;
   } sinais_t;

   function automatic logic eh_tipo_r(input logic [2:0] op);
      return op[2] == 1'b0;
   endfunction

endpackage

// File: rtl/unidade_controle_multiciclo_temporizador_espera.sv
// Counts consecutive memory-wait cycles; limite_c flags the cycle the count reaches
// LIMITE_ESPERA (never when LIMITE_ESPERA is 0).
module temporizador_espera #(
   parameter int unsigned LIMITE_ESPERA = 15
) (
   input  logic clk,
   input  logic rst,
   input  logic limpa,
   input  logic habilita,
   output logic limite_c
);

   localparam int unsigned LARGURA = (LIMITE_ESPERA > 1) ? $clog2(LIMITE_ESPERA) : 1;

   logic [LARGURA-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (limpa) begin
         cnt_d = '0;
      end else if (habilita) begin
         cnt_d = cnt_q + LARGURA'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // cnt_q holds the waits already elapsed, so this cycle is wait number cnt_q+1
   assign limite_c = (LIMITE_ESPERA != 0) && habilita &&
                     (cnt_q == LARGURA'(LIMITE_ESPERA - 1));

endmodule

// File: rtl/unidade_controle_multiciclo.sv
// Multicycle control FSM for the 8-bit processor: opcode decode, memory handshake,
// wait timeout and retired-instruction counter. HALT decode enabled by CONTROLE_HALT_EN.
module unidade_controle_multiciclo
   import unidade_controle_multiciclo_pkg::*;
#(
   parameter int unsigned LIMITE_ESPERA = 15,
   parameter int unsigned LARGURA_CONT  = 8
) (
   input  logic                    Clock,
   input  logic                    Reset,
   input  logic [2:0]              Opcode,
   input  logic [7:0]              Instr,
   input  logic                    MemPronta,
   output logic [1:0]              RegDst,
   output logic                    RegWrite,
   output logic                    MemRead,
   output logic                    MemWrite,
   output logic                    IRWrite,
   output logic                    PCWrite,
   output logic                    PCWriteCond,
   output logic                    IorD,
   output logic                    ALUSrcA,
   output logic [1:0]              ALUSrcB,
   output logic [1:0]              ALUOp,
   output logic [1:0]              PCSource,
   output logic                    MemToReg,
   output logic [2:0]              Estado,
   output logic                    ErroMem,
   output logic [LARGURA_CONT-1:0] ContInstr
);

   estado_t                 estado_q, estado_d;
   logic                    erro_q, erro_d;
   logic [LARGURA_CONT-1:0] cont_q, cont_d;
   sinais_t                 sin_c, sin_s;
   logic                    retira;
   logic                    espera_c, limpa_c, limite_c;

`ifndef CONTROLE_HALT_EN
   logic unused_instr;
   assign unused_instr = ^Instr;
`endif

   assign espera_c = ((estado_q == BUSCA) || (estado_q == MEMORIA)) && !MemPronta;
   assign limpa_c  = (estado_d != estado_q) || limite_c;

   temporizador_espera #(
      .LIMITE_ESPERA(LIMITE_ESPERA)
   ) u_temporizador (
      .clk     (Clock),
      .rst     (Reset),
      .limpa   (limpa_c),
      .habilita(espera_c),
      .limite_c(limite_c)
   );

   always_comb begin
      sin_c    = '0;
      estado_d = estado_q;
      erro_d   = erro_q;
      cont_d   = cont_q;
      retira   = 1'b0;
      if (limite_c) begin
         // timeout: drop everything, restart at fetch, do not retire
         erro_d   = 1'b1;
         estado_d = BUSCA;
      end else begin
         case (estado_q)
            BUSCA: begin
               sin_c.mem_read = 1'b1;
               if (MemPronta) begin
                  sin_c.ir_write  = 1'b1;
                  sin_c.pc_write  = 1'b1;
                  sin_c.alu_src_b = SRCB_UM;
                  sin_c.alu_op    = ALUOP_SOMA;
                  sin_c.pc_source = PCSRC_ALU;
                  estado_d        = DECODIFICA;
               end
            end
            DECODIFICA: begin
               sin_c.alu_src_b = SRCB_IMED;
               sin_c.alu_op    = ALUOP_SOMA;
               estado_d        = EXECUTA;
            end
            EXECUTA: begin
`ifdef CONTROLE_HALT_EN
               if (Instr == INSTR_HALT) begin
                  estado_d = PARADO;
                  retira   = 1'b1;
               end else
`endif
               case (Opcode)
                  OP_ADD, OP_SUB, OP_AND, OP_OR: begin
                     sin_c.alu_src_a = 1'b1;
                     sin_c.alu_src_b = SRCB_REGB;
                     sin_c.alu_op    = ALUOP_FUNCT;
                     estado_d        = ESCRITA;
                  end
                  OP_LW, OP_SW: begin
                     sin_c.alu_src_a = 1'b1;
                     sin_c.alu_src_b = SRCB_IMED;
                     sin_c.alu_op    = ALUOP_SOMA;
                     estado_d        = MEMORIA;
                  end
                  OP_BEQ: begin
                     sin_c.alu_src_a     = 1'b1;
                     sin_c.alu_src_b     = SRCB_REGB;
                     sin_c.alu_op        = ALUOP_SUB;
                     sin_c.pc_write_cond = 1'b1;
                     sin_c.pc_source     = PCSRC_ALUOUT;
                     estado_d            = BUSCA;
                     retira              = 1'b1;
                  end
                  OP_J: begin
                     sin_c.pc_write  = 1'b1;
                     sin_c.pc_source = PCSRC_DESVIO;
                     estado_d        = BUSCA;
                     retira          = 1'b1;
                  end
                  default: estado_d = BUSCA;
               endcase
            end
            MEMORIA: begin
               sin_c.iord      = 1'b1;
               sin_c.mem_read  = (Opcode == OP_LW);
               sin_c.mem_write = (Opcode == OP_SW);
               if (MemPronta) begin
                  if (Opcode == OP_SW) begin
                     estado_d = BUSCA;
                     retira   = 1'b1;
                  end else begin
                     estado_d = ESCRITA;
                  end
               end
            end
            ESCRITA: begin
               sin_c.reg_write = 1'b1;
               if (eh_tipo_r(Opcode)) begin
                  sin_c.reg_dst = REGDST_RD;
               end else if (Opcode == OP_LW) begin
                  sin_c.reg_dst    = REGDST_RT;
                  sin_c.mem_to_reg = 1'b1;
               end else begin
                  sin_c.reg_write = 1'b0;
                  sin_c.reg_dst   = REGDST_CONST;
               end
               estado_d = BUSCA;
               retira   = 1'b1;
            end
            PARADO: begin
`ifndef CONTROLE_HALT_EN
               estado_d = BUSCA;
`endif
            end
            default: estado_d = BUSCA;
         endcase
      end
      if (retira) begin
         cont_d = cont_q + LARGURA_CONT'(1);
      end
   end

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         estado_q <= BUSCA;
         erro_q   <= 1'b0;
         cont_q   <= '0;
      end else begin
         estado_q <= estado_d;
         erro_q   <= erro_d;
         cont_q   <= cont_d;
      end
   end

   // Reset silences every strobe at once, even mid-transfer
   assign sin_s = Reset ? '0 : sin_c;

   assign RegDst      = sin_s.reg_dst;
   assign RegWrite    = sin_s.reg_write;
   assign MemRead     = sin_s.mem_read;
   assign MemWrite    = sin_s.mem_write;
   assign IRWrite     = sin_s.ir_write;
   assign PCWrite     = sin_s.pc_write;
   assign PCWriteCond = sin_s.pc_write_cond;
   assign IorD        = sin_s.iord;
   assign ALUSrcA     = sin_s.alu_src_a;
   assign ALUSrcB     = sin_s.alu_src_b;
   assign ALUOp       = sin_s.alu_op;
   assign PCSource    = sin_s.pc_source;
   assign MemToReg    = sin_s.mem_to_reg;
   assign Estado      = estado_q;
   assign ErroMem     = erro_q;
   assign ContInstr   = cont_q;

endmodule

// File: tb/tb_unidade_controle_multiciclo.sv
// Self-checking bench for unidade_controle_multiciclo: per-instruction expected traces
// built from the instruction set rules, randomized waits and instruction mix.
module tb_unidade_controle_multiciclo;

   localparam int unsigned LIMITE = 15;
   localparam int unsigned LARG   = 8;

   logic            Clock = 1'b0;
   logic            Reset;
   logic [2:0]      Opcode;
   logic [7:0]      Instr;
   logic            MemPronta;
   logic [1:0]      RegDst, ALUSrcB, ALUOp, PCSource;
   logic            RegWrite, MemRead, MemWrite, IRWrite, PCWrite, PCWriteCond;
   logic            IorD, ALUSrcA, MemToReg, ErroMem;
   logic [2:0]      Estado;
   logic [LARG-1:0] ContInstr;

   always #5 Clock = ~Clock;

   unidade_controle_multiciclo #(
      .LIMITE_ESPERA(LIMITE),
      .LARGURA_CONT (LARG)
   ) dut (
      .Clock(Clock), .Reset(Reset), .Opcode(Opcode), .Instr(Instr), .MemPronta(MemPronta),
      .RegDst(RegDst), .RegWrite(RegWrite), .MemRead(MemRead), .MemWrite(MemWrite),
      .IRWrite(IRWrite), .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
      .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSource(PCSource),
      .MemToReg(MemToReg), .Estado(Estado), .ErroMem(ErroMem), .ContInstr(ContInstr)
   );

   typedef struct packed {
      logic [1:0] reg_dst;
      logic       reg_write, mem_read, mem_write, ir_write, pc_write, pc_write_cond, iord, alu_src_a;
      logic [1:0] alu_src_b, alu_op, pc_source;
      logic       mem_to_reg;
   } ctl_t;

   typedef struct packed {
      logic [2:0] est;
      ctl_t       ctl;
      logic       pronta;
      logic       erro;
   } passo_t;

   int         n_checks = 0;
   int         n_pass   = 0;
   int         cont_m   = 0;
   logic       erro_m   = 1'b0;
   logic [2:0] est_final_m;
   passo_t     trace[$];

   function automatic ctl_t obs();
      ctl_t c;
      c.reg_dst = RegDst;   c.reg_write = RegWrite; c.mem_read = MemRead;
      c.mem_write = MemWrite; c.ir_write = IRWrite; c.pc_write = PCWrite;
      c.pc_write_cond = PCWriteCond; c.iord = IorD; c.alu_src_a = ALUSrcA;
      c.alu_src_b = ALUSrcB; c.alu_op = ALUOp; c.pc_source = PCSource;
      c.mem_to_reg = MemToReg;
      return c;
   endfunction

   function automatic void empurra(input logic [2:0] e, input ctl_t c, input logic pr);
      passo_t p;
      p.est = e; p.ctl = c; p.pronta = pr; p.erro = erro_m;
      trace.push_back(p);
   endfunction

   // Expected cycle-by-cycle trace of one instruction, with wb fetch waits and wm memory waits
   function automatic void monta(input logic [7:0] ins, input int wb, input int wm,
                                 output bit conta);
      ctl_t       c;
      logic [2:0] op = ins[7:5];
      trace.delete();
      conta       = 1'b0;
      est_final_m = 3'd0;
      for (int k = 1; k <= wb; k++) begin
         c = '0;
         c.mem_read = (k % LIMITE) != 0;
         empurra(3'd0, c, 1'b0);
         if ((k % LIMITE) == 0) erro_m = 1'b1;
      end
      c = '0; c.mem_read = 1; c.ir_write = 1; c.pc_write = 1; c.alu_src_b = 2'b01;
      empurra(3'd0, c, 1'b1);
      c = '0; c.alu_src_b = 2'b10;
      empurra(3'd1, c, 1'($urandom));
`ifdef CONTROLE_HALT_EN
      if (ins == 8'hFF) begin
         empurra(3'd2, '0, 1'($urandom));
         conta = 1'b1;
         est_final_m = 3'd5;
         return;
      end
`endif
      c = '0;
      if (op[2] == 1'b0) begin
         c.alu_src_a = 1; c.alu_op = 2'b10;
      end else if (op == 3'b100 || op == 3'b101) begin
         c.alu_src_a = 1; c.alu_src_b = 2'b10;
      end else if (op == 3'b110) begin
         c.alu_src_a = 1; c.alu_op = 2'b01; c.pc_write_cond = 1; c.pc_source = 2'b01;
      end else begin
         c.pc_write = 1; c.pc_source = 2'b10;
      end
      empurra(3'd2, c, 1'($urandom));
      if (op[2] == 1'b1 && op[1] == 1'b1) begin
         conta = 1'b1;
         return;
      end
      if (op[2] == 1'b1) begin
         c = '0; c.iord = 1; c.mem_read = (op == 3'b100); c.mem_write = (op == 3'b101);
         for (int k = 1; k <= wm; k++) begin
            if (k == LIMITE) begin
               empurra(3'd3, '0, 1'b0);
               erro_m = 1'b1;
               return;
            end
            empurra(3'd3, c, 1'b0);
         end
         empurra(3'd3, c, 1'b1);
         if (op == 3'b101) begin
            conta = 1'b1;
            return;
         end
      end
      c = '0; c.reg_write = 1;
      if (op[2] == 1'b0) c.reg_dst = 2'b01;
      else c.mem_to_reg = 1;
      empurra(3'd4, c, 1'($urandom));
      conta = 1'b1;
   endfunction

   // Entered and left at posedge+1; nmax>0 stops after that many cycles
   task automatic run_instr(input logic [7:0] ins, input int wb, input int wm, input int nmax);
      bit conta;
      int n;
      monta(ins, wb, wm, conta);
      n = (nmax > 0 && nmax < trace.size()) ? nmax : trace.size();
      for (int i = 0; i < n; i++) begin
         Opcode = ins[7:5]; Instr = ins; MemPronta = trace[i].pronta;
         #3;
         n_checks++;
         if (Estado !== trace[i].est || obs() !== trace[i].ctl || ErroMem !== trace[i].erro)
            $display("FAIL passo ins=%h i=%0d: got estado=%0d ctl=%h erro=%b, want estado=%0d ctl=%h erro=%b",
                     ins, i, Estado, obs(), ErroMem, trace[i].est, trace[i].ctl, trace[i].erro);
         else n_pass++;
         @(posedge Clock); #1;
      end
      if (n == trace.size()) begin
         if (conta) cont_m++;
         n_checks++;
         if (Estado !== est_final_m || ContInstr !== LARG'(cont_m) || ErroMem !== erro_m)
            $display("FAIL fim ins=%h: got estado=%0d cont=%0d erro=%b, want estado=%0d cont=%0d erro=%b",
                     ins, Estado, ContInstr, ErroMem, est_final_m, LARG'(cont_m), erro_m);
         else n_pass++;
      end
   endtask

   task automatic do_reset();
      Reset = 1'b1; MemPronta = 1'b1; Opcode = 3'($urandom); Instr = 8'($urandom);
      #3;
      n_checks++;
      if (obs() !== '0 || Estado !== 3'd0 || ErroMem !== 1'b0 || ContInstr !== '0)
         $display("FAIL reset: got ctl=%h estado=%0d erro=%b cont=%0d, want all 0",
                  obs(), Estado, ErroMem, ContInstr);
      else n_pass++;
      @(posedge Clock); #1;
      n_checks++;
      if (obs() !== '0 || Estado !== 3'd0 || ContInstr !== '0)
         $display("FAIL reset_edge: got ctl=%h estado=%0d cont=%0d, want all 0", obs(), Estado, ContInstr);
      else n_pass++;
      Reset = 1'b0;
      cont_m = 0;
      erro_m = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
   endtask

   task automatic test_add();
      run_instr(8'h00, 0, 0, 0);
   endtask

   task automatic test_lw_wait();
      run_instr({3'b100, 5'($urandom)}, 0, 3, 0);
   endtask

   task automatic test_beq_j();
      run_instr({3'b110, 5'($urandom)}, 0, 0, 0);
      run_instr({3'b111, 5'h0A}, 0, 0, 0);
   endtask

   task automatic test_timeout();
      do_reset();
      run_instr(8'h00, 2 * LIMITE + 5, 0, 0);
      run_instr({3'b001, 5'($urandom)}, 0, 0, 0);
      run_instr({3'b100, 5'($urandom)}, 0, LIMITE, 0);
      run_instr({3'b100, 5'($urandom)}, 0, LIMITE - 1, 0);
      run_instr({3'b101, 5'($urandom)}, LIMITE - 1, 0, 0);
      do_reset();
   endtask

   task automatic test_reset_abort();
      do_reset();
      run_instr(8'h00, 0, 0, 0);
      run_instr({3'b101, 5'($urandom)}, 0, 5, 4);
      MemPronta = 1'b0;
      #1;
      n_checks++;
      if (MemWrite !== 1'b1 || Estado !== 3'd3)
         $display("FAIL sw_mem: got memwrite=%b estado=%0d, want 1 3", MemWrite, Estado);
      else n_pass++;
      Reset = 1'b1;
      #1;
      n_checks++;
      if (obs() !== '0 || Estado !== 3'd0 || ContInstr !== '0)
         $display("FAIL reset_async: got ctl=%h estado=%0d cont=%0d, want 0 0 0", obs(), Estado, ContInstr);
      else n_pass++;
      @(posedge Clock); #1;
      Reset = 1'b0;
      cont_m = 0;
      erro_m = 1'b0;
   endtask

   task automatic test_halt();
      do_reset();
      run_instr(8'hFF, 0, 0, 0);
`ifdef CONTROLE_HALT_EN
      for (int i = 0; i < 10; i++) begin
         MemPronta = 1'($urandom);
         #3;
         n_checks++;
         if (Estado !== 3'd5 || obs() !== '0 || ContInstr !== LARG'(cont_m))
            $display("FAIL halt: got estado=%0d ctl=%h cont=%0d, want 5 0 %0d",
                     Estado, obs(), ContInstr, cont_m);
         else n_pass++;
         @(posedge Clock); #1;
      end
      do_reset();
`endif
   endtask

   task automatic test_random();
      logic [7:0] ins;
      int         wm;
      do_reset();
      for (int i = 0; i < 40; i++) begin
         ins = 8'($urandom);
         if (ins == 8'hFF) ins = 8'hFE;
         wm = ($urandom_range(0, 7) == 0) ? $urandom_range(LIMITE - 3, LIMITE + 2) : $urandom_range(0, 3);
         run_instr(ins, $urandom_range(0, 3), wm, 0);
      end
   endtask

   task automatic test_wrap();
      logic [7:0] ins;
      do_reset();
      for (int i = 0; i < 260; i++) begin
         ins = {2'b11, 6'($urandom)};
         if (ins == 8'hFF) ins = 8'hE1;
         run_instr(ins, 0, 0, 0);
      end
   endtask

   initial begin
      Reset = 1'b1; MemPronta = 1'b0; Opcode = 3'd0; Instr = 8'd0;
      test_reset();
      test_add();
      test_lw_wait();
      test_beq_j();
      test_timeout();
      test_reset_abort();
      test_halt();
      test_random();
      test_wrap();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
